// File: rtl/sr_ms_checker.sv
// Response checker for an SR master-slave flop: samples s/r/qm/qs on each rising edge,
// tracks a reference state, and flags mismatches and illegal s=r=1 inputs.
module sr_ms_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             qm,
  input  logic             qs,
  output logic             err,
  output logic             illegal,
  output logic             exp_q,
  output logic             known,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             exp_q_q, exp_q_d;
  logic             known_q, known_d;
  logic             err_q, err_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Next-state logic: frozen when en is low, pulses default to zero.
  always_comb begin
    state_d       = state_q;
    exp_q_d       = exp_q_q;
    err_d         = 1'b0;
    illegal_d     = 1'b0;
    err_cnt_d     = err_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          state_d = SYNC;
        end
        SYNC: begin
          if (s && r) begin
            illegal_d = 1'b1;
          end else if (s ^ r) begin
            exp_q_d = s;
            state_d = CHECK;
          end else begin
            state_d = SYNC;
          end
        end
        CHECK: begin
          // An X on qm/qs makes the condition non-true, so it is not flagged.
          if ((qm != exp_q_q) || (qs != exp_q_q)) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
          end
          if (s && r) begin
            illegal_d = 1'b1;
            state_d   = SYNC;
          end else if (s ^ r) begin
            exp_q_d = s;
          end else begin
            exp_q_d = exp_q_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (err_d) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
    if (illegal_d) begin
      illegal_cnt_d = sat_inc(illegal_cnt_q);
    end else begin
      illegal_cnt_d = illegal_cnt_q;
    end
    known_d = (state_d == CHECK);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      exp_q_q       <= 1'b0;
      known_q       <= 1'b0;
      err_q         <= 1'b0;
      illegal_q     <= 1'b0;
      err_cnt_q     <= {CNT_W{1'b0}};
      illegal_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      exp_q_q       <= exp_q_d;
      known_q       <= known_d;
      err_q         <= err_d;
      illegal_q     <= illegal_d;
      err_cnt_q     <= err_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign err         = err_q;
  assign illegal     = illegal_q;
  assign exp_q       = exp_q_q;
  assign known       = known_q;
  assign err_cnt     = err_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_sr_ms_checker.sv
// Scoreboard bench for sr_ms_checker: a behavioural flop (with injectable faults) drives
// two checkers (CNT_W=8 and CNT_W=2); a reference model predicts every cycle's outputs.
module tb_sr_ms_checker;

  logic clk = 1'b0;
  logic rst, en, s, r;
  logic qm_f, qs_f, glitch;
  int   fault;
  logic qm_obs, qs_obs;

  logic       err8, ill8, expq8, known8;
  logic [7:0] errc8, illc8;
  logic       err2, ill2, expq2, known2;
  logic [1:0] errc2, illc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_ms_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .qm(qm_obs), .qs(qs_obs),
    .err(err8), .illegal(ill8), .exp_q(expq8), .known(known8),
    .err_cnt(errc8), .illegal_cnt(illc8)
  );

  sr_ms_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .qm(qm_obs), .qs(qs_obs),
    .err(err2), .illegal(ill2), .exp_q(expq2), .known(known2),
    .err_cnt(errc2), .illegal_cnt(illc2)
  );

  // Behavioural master-slave flop: master on rising edge, slave on falling edge.
  initial begin
    qm_f = 1'b0;
    qs_f = 1'b0;
  end
  always @(posedge clk) begin
    if (s && !r) qm_f <= 1'b1;
    else if (r && !s) qm_f <= 1'b0;
  end
  always @(negedge clk) qs_f <= qm_f;

  assign qm_obs = qm_f ^ ((fault == 2) ? glitch : 1'b0);
  assign qs_obs = (fault == 1) ? 1'b0 : qs_f;

  typedef struct packed {
    logic       err;
    logic       ill;
    logic       expq;
    logic       known;
    logic [7:0] errc;
    logic [7:0] illc;
    logic [1:0] errc2;
    logic [1:0] illc2;
  } exp_t;

  exp_t exp_qu[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: phase 0 = not sampling, 1 = waiting for a defined set/reset, 2 = tracking.
  int   m_phase = 0;
  logic m_val = 1'b0;
  int   m_errc = 0, m_illc = 0, m_errc2 = 0, m_illc2 = 0;

  initial begin
    exp_t e;
    logic pe, pi;
    forever begin
      @(posedge clk);
      pe = 1'b0;
      pi = 1'b0;
      if (rst) begin
        m_phase = 0; m_val = 1'b0;
        m_errc = 0; m_illc = 0; m_errc2 = 0; m_illc2 = 0;
      end else if (en) begin
        if (m_phase == 0) begin
          m_phase = 1;
        end else if (m_phase == 1) begin
          pi = s & r;
          if (s != r) begin
            m_val = s;
            m_phase = 2;
          end
        end else begin
          pe = (qm_obs != m_val) || (qs_obs != m_val);
          pi = s & r;
          if (pi) m_phase = 1;
          else if (s != r) m_val = s;
        end
        if (pe) begin
          if (m_errc < 255) m_errc++;
          if (m_errc2 < 3) m_errc2++;
        end
        if (pi) begin
          if (m_illc < 255) m_illc++;
          if (m_illc2 < 3) m_illc2++;
        end
      end
      e.err   = pe;
      e.ill   = pi;
      e.expq  = m_val;
      e.known = (m_phase == 2);
      e.errc  = 8'(m_errc);
      e.illc  = 8'(m_illc);
      e.errc2 = 2'(m_errc2);
      e.illc2 = 2'(m_illc2);
      exp_qu.push_back(e);
    end
  end

  // Monitor: outputs are valid every cycle; compare shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_qu.size() == 0) begin
        chk("scoreboard_empty", 8'd1, 8'd0);
      end else begin
        e = exp_qu.pop_front();
        chk("err", {7'd0, err8}, {7'd0, e.err});
        chk("illegal", {7'd0, ill8}, {7'd0, e.ill});
        chk("exp_q", {7'd0, expq8}, {7'd0, e.expq});
        chk("known", {7'd0, known8}, {7'd0, e.known});
        chk("err_cnt", errc8, e.errc);
        chk("illegal_cnt", illc8, e.illc);
        chk("err2", {7'd0, err2}, {7'd0, e.err});
        chk("illegal2", {7'd0, ill2}, {7'd0, e.ill});
        chk("err_cnt_w2", {6'd0, errc2}, {6'd0, e.errc2});
        chk("illegal_cnt_w2", {6'd0, illc2}, {6'd0, e.illc2});
      end
    end
  end

  task automatic drive(input logic se, input logic ss, input logic rr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = se; s = ss; r = rr;
      glitch = 1'($urandom_range(0, 1));
    end
  endtask

  // Assert reset between edges and verify outputs clear before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_err", {7'd0, err8}, 8'd0);
    chk("rst_illegal", {7'd0, ill8}, 8'd0);
    chk("rst_exp_q", {7'd0, expq8}, 8'd0);
    chk("rst_known", {7'd0, known8}, 8'd0);
    chk("rst_err_cnt", errc8, 8'd0);
    chk("rst_illegal_cnt", illc8, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s = 1'b0; r = 1'b0; fault = 0; glitch = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3);
    rst = 1'b0;
    // Sync, nominal follow, then illegal inputs.
    drive(1'b1, 1'b0, 1'b1, 3);
    drive(1'b1, 1'b1, 1'b0, 2);
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b1, 1'b1, 1'b1, 3);
    // Stuck slave: mismatches every tracked edge, narrow counter saturates.
    drive(1'b1, 1'b1, 1'b0, 1);
    fault = 1;
    drive(1'b1, 1'b1, 1'b0, 8);
    drive(1'b0, 1'b1, 1'b0, 3);
    drive(1'b1, 1'b1, 1'b0, 2);
    fault = 0;
    drive(1'b1, 1'b0, 1'b1, 4);
    async_reset();
    drive(1'b1, 1'b1, 1'b0, 4);
    // Randomized traffic with occasional faults and resets.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 49) == 0) fault = int'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) async_reset();
      drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
